debug_frame_arbiter: RTL and testbench
======================================

Name: debug_frame_arbiter

Overview:
- Shares one 40-bit serial debug/monitor link between NUM_REQ requesters (sound, keyboard/mouse, status) inside the NeXT ASIC.
- Arbitrates requests round-robin, captures the winner's parallel frame, and drives the frame out as data_start + sout.
- Output timing matches the DebugDataReceiver framing: data_start is high for one cycle, then 40 bits follow MSB-first, one per clk.
- Enforces a fixed idle gap between frames.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
FRAME_W, 40, frame width in bits
GAP_CYCLES, 5, minimum sout=0 idle cycles after the last bit (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset; one clock, asynchronous assert, active-low
req  in  NUM_REQ  per-requester frame request, level; held until gnt
req_data  in  NUM_REQ*FRAME_W  packed frames; requester i at [i*FRAME_W +: FRAME_W]; stable while req[i]=1
gnt  out  NUM_REQ  one-hot, one-cycle pulse: frame of requester i captured
data_start  out  1  frame-start strobe, one cycle, sout=0 during it
sout  out  1  serial data, MSB (bit FRAME_W-1) first
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst_n=0, async): state=IDLE; gnt=0, data_start=0, sout=0, busy=0; shift register=0; bit counter=0; last_gnt pointer=NUM_REQ-1, so req[0] has highest priority first.
- Reset mid-frame aborts immediately. sout drops to 0 asynchronously. There is no partial-frame completion after release.
- All outputs are registered.
- States: IDLE, START, SHIFT, GAP.
- IDLE: at an edge with req!=0, select the first set bit searching from last_gnt+1 upward, wrapping modulo NUM_REQ. On that edge:
  - latch its req_data into the shift register;
  - last_gnt<=winner; gnt<=onehot(winner); data_start<=1;
  - go to START.
  - With req=0, stay in IDLE with all outputs 0.
- START (1 cycle): gnt and data_start high, sout=0, busy=1. Next edge: gnt<=0, data_start<=0, sout<=bit FRAME_W-1, counter<=FRAME_W-1, go to SHIFT.
- SHIFT (FRAME_W cycles): sout shows bit FRAME_W-1 down to bit 0. Each edge shifts left and decrements the counter. At the edge with counter==0: sout<=0, counter<=GAP_CYCLES-1, go to GAP.
- GAP (GAP_CYCLES cycles): sout=0. At the edge with counter==0, go to IDLE.
- Latency: req sampled at edge E0 -> data_start/gnt in cycle E0..E1 -> bit39 in E1..E2 -> bit0 in E40..E41 -> GAP for GAP_CYCLES cycles -> IDLE for 1 cycle. Earliest next data_start is at E0+FRAME_W+GAP_CYCLES+2 (47 edges with defaults).
- req is ignored outside IDLE. A requester drops req on seeing gnt; a req still high in the next IDLE is re-arbitrated normally.
- Simultaneous requests are served strictly round-robin; no requester waits more than NUM_REQ frames.
- req_data changing after capture has no effect on the frame in flight.
- The pointer updates only on grant. Bits of req at index >= NUM_REQ do not exist; there is no invalid index.

Optional Feature:
- Macro: DEBUG_FRAME_ARB_COUNT_EN.
- Defined:
  - adds output frame_count[15:0], reset 0;
  - increments by 1 at the edge leaving SHIFT (last bit sent);
  - wraps 16'hFFFF->0;
  - unaffected by GAP/IDLE time.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then req=3'b001 with req_data[0]=40'hA9F0AAAAA9 for one grant:
  - gnt=001 and data_start=1 in the same cycle;
  - next 40 cycles sout=1,0,1,0,1,0,0,1,1,1,1,1,0,0,0,0,... ending 1,0,0,1;
  - then sout=0 for 5 cycles; busy falls after the GAP.
- req=3'b111 held high continuously: grants occur in order 001,010,100,001. Consecutive data_start pulses are exactly 47 cycles apart.
- req=3'b101 after last grant to requester 0: next gnt=100, then 001; requester 1 is never granted.
- rst_n pulsed low during SHIFT bit 20:
  - sout, data_start, busy go 0 immediately;
  - after release with req=3'b010, a fresh frame starts with gnt=010 and full 40 bits.
- req_data[1] changed mid-frame from 40'hFFFFFFFFFF to 0: the serialized frame is all ones.
- With DEBUG_FRAME_ARB_COUNT_EN: 3 frames -> frame_count=3. Preload near wrap via 65537 frames (long test) -> frame_count=1.

Source files
------------

// File: rtl/debug_frame_arbiter.sv
// Round-robin arbiter sharing one serial debug link: data_start strobe, then FRAME_W bits MSB-first, then an idle gap.
// Optional frame counter output enabled by DEBUG_FRAME_ARB_COUNT_EN.
module debug_frame_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned FRAME_W    = 40,
  parameter int unsigned GAP_CYCLES = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       data_start,
  output logic                       sout,
`ifdef DEBUG_FRAME_ARB_COUNT_EN
  output logic [15:0]                frame_count,
`endif
  output logic                       busy
);

  localparam int unsigned PTR_W   = $clog2(NUM_REQ);
  localparam int unsigned CAND_W  = PTR_W + 1;
  localparam int unsigned CNT_MAX = (FRAME_W > GAP_CYCLES) ? FRAME_W : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, START, SHIFT, GAP} state_e;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     last_gnt_q, last_gnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 ds_q, ds_d;
  logic                 sout_q, sout_d;
  logic                 busy_q, busy_d;
  logic [15:0]          fcnt_q, fcnt_d;

  logic                 win_valid;
  logic [PTR_W-1:0]     win_idx;
  logic [CAND_W-1:0]    cand;

  // Search from last_gnt+1 upward, wrapping, for the first pending request.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = CAND_W'(last_gnt_q) + CAND_W'(k);
      if (cand >= CAND_W'(NUM_REQ)) cand = cand - CAND_W'(NUM_REQ);
      if (!win_valid && req[cand[PTR_W-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = '0;
    ds_d       = 1'b0;
    sout_d     = 1'b0;
    fcnt_d     = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          shreg_d    = req_data[win_idx*FRAME_W +: FRAME_W];
          last_gnt_d = win_idx;
          gnt_d      = NUM_REQ'(1) << win_idx;
          ds_d       = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        sout_d  = shreg_q[FRAME_W-1];
        shreg_d = shreg_q << 1;
        cnt_d   = CNT_W'(FRAME_W - 1);
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          fcnt_d  = fcnt_q + 16'd1;
          state_d = GAP;
        end else begin
          sout_d  = shreg_q[FRAME_W-1];
          shreg_d = shreg_q << 1;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Async reset aborts any frame in flight; no resumption after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      last_gnt_q <= PTR_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      ds_q       <= 1'b0;
      sout_q     <= 1'b0;
      busy_q     <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      ds_q       <= ds_d;
      sout_q     <= sout_d;
      busy_q     <= busy_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign data_start = ds_q;
  assign sout       = sout_q;
  assign busy       = busy_q;

`ifdef DEBUG_FRAME_ARB_COUNT_EN
  assign frame_count = fcnt_q;
`else
  logic unused_fcnt;
  assign unused_fcnt = ^fcnt_q;
`endif

endmodule

// File: tb/tb_debug_frame_arbiter.sv
// Directed bench for debug_frame_arbiter: framing, round-robin order, mid-frame reset, capture isolation.
module tb_debug_frame_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    req;
  logic [119:0]  req_data;
  logic [2:0]    gnt;
  logic          data_start;
  logic          sout;
  logic          busy;
`ifdef DEBUG_FRAME_ARB_COUNT_EN
  logic [15:0]   frame_count;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c0, c1, c2, c3;

  debug_frame_arbiter #(.NUM_REQ(3), .FRAME_W(40), .GAP_CYCLES(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .data_start (data_start),
    .sout       (sout),
`ifdef DEBUG_FRAME_ARB_COUNT_EN
    .frame_count(frame_count),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gnt(output int c);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt != 3'b000) break;
    end
    c = cyc;
    chk("gnt_seen", 64'(gnt != 3'b000), 64'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic check_frame(input string tag, input logic [39:0] exp);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk($sformatf("%s_b%0d", tag, 39 - i), 64'(sout), 64'(exp[39-i]));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = 3'b000;
    req_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt",  64'(gnt), 64'd0);
    chk("rst_ds",   64'(data_start), 64'd0);
    chk("rst_sout", 64'(sout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Single frame from requester 0
    req_data[0 +: 40] = 40'hA9F0AAAAA9;
    req = 3'b001;
    @(negedge clk);
    chk("f0_gnt",  64'(gnt), 64'd1);
    chk("f0_ds",   64'(data_start), 64'd1);
    chk("f0_sout", 64'(sout), 64'd0);
    chk("f0_busy", 64'(busy), 64'd1);
    req = 3'b000;
    check_frame("f0", 40'hA9F0AAAAA9);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("f0_gap_sout", 64'(sout), 64'd0);
      chk("f0_gap_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    chk("f0_idle_busy", 64'(busy), 64'd0);
    chk("f0_idle_ds",   64'(data_start), 64'd0);

    // All three requesting from fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 3'b111;
    wait_gnt(c0); chk("rr_g0", 64'(gnt), 64'b001); chk("rr_ds0", 64'(data_start), 64'd1);
    wait_gnt(c1); chk("rr_g1", 64'(gnt), 64'b010); chk("rr_ds1", 64'(data_start), 64'd1);
    wait_gnt(c2); chk("rr_g2", 64'(gnt), 64'b100);
    wait_gnt(c3); chk("rr_g3", 64'(gnt), 64'b001);
    chk("rr_gap01", 64'(c1 - c0), 64'd47);
    chk("rr_gap12", 64'(c2 - c1), 64'd47);
    chk("rr_gap23", 64'(c3 - c2), 64'd47);
    req = 3'b000;
    wait_idle();

    // Requesters 0 and 2 after last grant went to 0
    req = 3'b101;
    wait_gnt(c0); chk("p_g0", 64'(gnt), 64'b100);
    wait_gnt(c1); chk("p_g1", 64'(gnt), 64'b001);
    wait_gnt(c2); chk("p_g2", 64'(gnt), 64'b100);
    req = 3'b000;
    wait_idle();

    // Reset during SHIFT bit 20, then a fresh full frame
    req_data[40 +: 40] = 40'h5AC3960FF1;
    req = 3'b010;
    wait_gnt(c0); chk("mr_g0", 64'(gnt), 64'b010);
    repeat (20) @(negedge clk);
    chk("mr_bit20", 64'(sout), 64'(1'b1));
    #1 rst_n = 1'b0;
    #1;
    chk("mr_sout", 64'(sout), 64'd0);
    chk("mr_ds",   64'(data_start), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(c1); chk("mr_g1", 64'(gnt), 64'b010); chk("mr_ds1", 64'(data_start), 64'd1);
    req = 3'b000;
    check_frame("mr", 40'h5AC3960FF1);
    wait_idle();
`ifdef DEBUG_FRAME_ARB_COUNT_EN
    chk("cnt_1", 64'(frame_count), 64'd1);
`endif

    // Frame content is isolated from req_data changes after capture
    req_data[40 +: 40] = 40'hFFFFFFFFFF;
    req = 3'b010;
    wait_gnt(c0); chk("cap_g", 64'(gnt), 64'b010);
    req_data[40 +: 40] = 40'h0;
    req = 3'b000;
    check_frame("cap", 40'hFFFFFFFFFF);
    wait_idle();
`ifdef DEBUG_FRAME_ARB_COUNT_EN
    chk("cnt_2", 64'(frame_count), 64'd2);
`endif

    req = 3'b001;
    wait_gnt(c0); chk("f3_g", 64'(gnt), 64'b001);
    req = 3'b000;
    check_frame("f3", 40'hA9F0AAAAA9);
    wait_idle();
`ifdef DEBUG_FRAME_ARB_COUNT_EN
    chk("cnt_3", 64'(frame_count), 64'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
